// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Serial-side and CPU-read-side signal bundle for uart_rx_fifo.
//                The master modport belongs to the environment, which drives
//                the baud tick, the serial line and the read controls. The
//                slave modport belongs to the receiver, which returns the FIFO
//                head, its occupancy and the sticky error flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  // Serial side and read controls
  logic               baudclk16;
  logic               rxd;
  logic               rd_strobe;
  logic               clr_err;

  // FIFO head, occupancy and status
  logic [7:0]         data;
  logic               ready;
  logic [LEVEL_W-1:0] level;
  logic               overrun;
  logic               frame_err;

  modport master (
    output baudclk16, rxd, rd_strobe, clr_err,
    input  data, ready, level, overrun, frame_err
  );

  modport slave (
    input  baudclk16, rxd, rd_strobe, clr_err,
    output data, ready, level, overrun, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 8N1 UART receiver timed from a 16x baud tick, feeding a
//                show-ahead receive FIFO read through an edge-detected strobe.
//                Overrun and framing errors are kept as sticky flags.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire           clk,
  input  wire           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  // --------------------------------------------------------------------------
  // rxd synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxd_s;

  // Shift the raw pin through the synchroniser chain; idles high out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rxd};
    end
  end

  assign w_rxd_s = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Receive state machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_tick,  w_tick_nxt;
  logic [2:0] r_bit,   w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  // Set after a low stop bit: a new start bit is only accepted once the line
  // has been seen high again, so a held break does not look like frames.
  logic       r_brk,   w_brk_nxt;
  logic       w_push;
  logic       w_frame_set;

  // Register the FSM state, tick/bit counters, shift register and break flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_brk   <= w_brk_nxt;
    end
  end

  // Next-state logic; everything advances only on baud tick cycles
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_brk_nxt   = r_brk;
    w_push      = 1'b0;
    w_frame_set = 1'b0;

    if (bus.baudclk16) begin
      case (r_state)
        ST_IDLE: begin
          if (r_brk) begin
            if (w_rxd_s) begin
              w_brk_nxt = 1'b0;
            end
          end else if (!w_rxd_s) begin
            w_state_nxt = ST_START;
            w_tick_nxt  = 4'd0;
          end
        end

        ST_START: begin
          // Eighth tick after the falling edge is the start-bit midpoint
          if (r_tick == 4'd7) begin
            if (!w_rxd_s) begin
              w_state_nxt = ST_DATA;
              w_tick_nxt  = 4'd0;
              w_bit_nxt   = 3'd0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end

        ST_DATA: begin
          if (r_tick == 4'd15) begin
            w_tick_nxt  = 4'd0;
            w_shift_nxt = {w_rxd_s, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_bit_nxt = r_bit + 3'd1;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end

        ST_STOP: begin
          // Leaving at the stop-bit midpoint leaves half a bit of slack for
          // the next start edge of a back-to-back frame.
          if (r_tick == 4'd15) begin
            w_tick_nxt  = 4'd0;
            w_state_nxt = ST_IDLE;
            if (w_rxd_s) begin
              w_push = 1'b1;
            end else begin
              w_frame_set = 1'b1;
              w_brk_nxt   = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read strobe edge detect
  // --------------------------------------------------------------------------
  logic r_rd_d;

  // Remember last cycle's strobe so a held strobe pops only once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_d <= 1'b0;
    end else begin
      r_rd_d <= bus.rd_strobe;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_ovr_set;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = bus.rd_strobe && !r_rd_d && !w_empty;
  // A full FIFO still accepts a byte when a pop frees a slot on the same edge
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign w_count   = r_wptr - r_rptr;

  // Advance the write and read pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= r_shift;
    end
  end

  assign bus.data  = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign bus.ready = !w_empty;
  assign bus.level = LEVEL_W'(w_count);

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
  logic r_overrun;
  logic r_frame_err;

  // Set events take priority over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_err) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (bus.clr_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. Frames are driven bit
//                by bit on rxd; a queue-based model of the FIFO and the two
//                sticky flags supplies every expected value.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH     = 16;
  localparam int BIT_CLKS  = 64;            // 16 ticks x 4 clocks
  localparam int FRAME_CLK = 10 * BIT_CLKS;
  localparam int PUSH_K    = 612;           // stop-bit sample edge, clocks after the sync tick
  localparam int NO        = -1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: queue of bytes held plus the two sticky flags
  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_ferr;

  int n_total = 0;
  int n_bad   = 0;

  // Baud tick: one clock high out of every four, changed on falling edges
  initial begin
    bus.baudclk16 = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.baudclk16 = 1'b1;
      @(negedge clk);
      bus.baudclk16 = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".level"},     32'(bus.level),     32'(q.size()));
    check({tag, ".ready"},     32'(bus.ready),     32'(q.size() != 0));
    check({tag, ".data"},      32'(bus.data),      (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
  endtask

  // Return just after a clock edge on which the DUT saw a baud tick
  task automatic sync_tick();
    bit seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      if (bus.baudclk16) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  // Drive one 8N1 frame. rd_at starts a 3-cycle read strobe at that clock
  // offset; abort_at pulses reset at that offset and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int rd_at, input int abort_at, input string tag);
    int  idx;
    bit  popping;
    bit  full_before;
    sync_tick();
    for (int k = 0; k < FRAME_CLK; k++) begin
      @(negedge clk);
      if (k == PUSH_K - 1 && abort_at < 0) begin
        check({tag, ".pre_level"}, 32'(bus.level), 32'(q.size()));
      end
      if (k == PUSH_K && abort_at < 0) begin
        full_before = (q.size() == DEPTH);
        popping     = (rd_at == PUSH_K - 1) && (q.size() != 0);
        if (popping) void'(q.pop_front());
        if (!stop_ok) begin
          m_ferr = 1'b1;
        end else if (full_before && !popping) begin
          m_ovr = 1'b1;
        end else begin
          q.push_back(b);
        end
        check_state({tag, ".push"});
      end
      if (k == abort_at) begin
        reset   = 1'b1;
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        q.delete();
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        return;
      end
      idx = k / BIT_CLKS;
      if (idx == 0)      bus.rxd = 1'b0;
      else if (idx <= 8) bus.rxd = b[idx-1];
      else               bus.rxd = stop_ok;
      if (rd_at >= 0 && k == rd_at)     bus.rd_strobe = 1'b1;
      if (rd_at >= 0 && k == rd_at + 3) bus.rd_strobe = 1'b0;
    end
    @(negedge clk);
    bus.rxd = 1'b1;
  endtask

  // Hold rd_strobe for len cycles; exactly one pop is expected
  task automatic do_read(input int len, input string tag);
    @(negedge clk);
    check_state({tag, ".pre"});
    bus.rd_strobe = 1'b1;
    for (int j = 0; j < len; j++) @(negedge clk);
    if (q.size() != 0) void'(q.pop_front());
    check_state({tag, ".post"});
    bus.rd_strobe = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    check_state("clr");
  endtask

  // Quarter-bit low pulse that must be rejected as a glitch
  task automatic send_glitch();
    sync_tick();
    @(negedge clk);
    bus.rxd = 1'b0;
    repeat (16) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (100) @(negedge clk);
    check_state("glitch");
  endtask

  initial begin
    logic [7:0] rb;
    int         op;

    reset         = 1'b1;
    bus.rxd       = 1'b1;
    bus.rd_strobe = 1'b0;
    bus.clr_err   = 1'b0;
    m_ovr         = 1'b0;
    m_ferr        = 1'b0;
    repeat (5) @(negedge clk);
    check_state("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single frame, then a held strobe popping once
    send_frame(8'hA5, 1'b1, NO, NO, "a5");
    do_read(3, "a5_rd");

    // Fill to the brim, overflow by one, then drain in order
    for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), 1'b1, NO, NO, "fill");
    send_frame(8'h11, 1'b1, NO, NO, "ovr");
    for (int i = 0; i < DEPTH; i++) do_read(int'($urandom_range(1, 4)), "drain");
    pulse_clr();

    // Framing error with a one-bit break, cleared, then a good frame
    send_frame(8'h00, 1'b0, NO, NO, "ferr");
    pulse_clr();
    send_frame(8'h3C, 1'b1, NO, NO, "3c");
    do_read(1, "3c_rd");

    // Glitch rejection
    send_glitch();

    // Full FIFO: last stop sample lands on the first strobe cycle
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, NO, NO, "refill");
    send_frame(8'($urandom), 1'b1, PUSH_K - 1, NO, "coinc");
    repeat (4) @(negedge clk);
    check_state("coinc_after");
    for (int i = 0; i < DEPTH; i++) do_read(int'($urandom_range(1, 4)), "coinc_drain");

    // Empty FIFO: push and strobe on the same edge leaves one entry
    send_frame(8'($urandom), 1'b1, PUSH_K - 1, NO, "empty_pp");
    do_read(2, "empty_pp_rd");

    // Reset in the middle of data bit 4, then a clean frame
    send_frame(8'($urandom), 1'b1, NO, 5 * BIT_CLKS + 20, "abort");
    repeat (20) @(negedge clk);
    check_state("post_rst");
    send_frame(8'h5A, 1'b1, NO, NO, "5a");
    do_read(1, "5a_rd");

    // Random mix of frames, bad frames, reads and clears
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 9));
      rb = 8'($urandom);
      if (op < 5)       send_frame(rb, 1'b1, ($urandom_range(0, 3) == 0) ? PUSH_K - 1 : NO, NO, "rnd_frame");
      else if (op == 5) send_frame(rb, 1'b0, NO, NO, "rnd_bad");
      else if (op < 9)  do_read(int'($urandom_range(1, 4)), "rnd_rd");
      else              pulse_clr();
      repeat (int'($urandom_range(0, 20))) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_state("final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
